// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to TX and RX, parity
// polarity codes and the default payload width.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Datapath for the UART transmitter: baud counter, data bit counter and the
// LSB-first shift register.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  active,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_bit,
  output logic                  bit_done,
  output logic                  last_data_bit
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

  logic [BW-1:0]         baud_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (!active || bit_done) baud_cnt <= '0;
      else                     baud_cnt <= baud_cnt + BW'(1);

      if (load)          shreg <= load_data;
      else if (shift_en) shreg <= shreg >> 1;

      if (load)          bit_cnt <= '0;
      else if (shift_en) bit_cnt <= last_data_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  // ser_bit is the bit the line should carry after the coming edge, so a
  // shifting edge already presents the next data bit.
  assign ser_bit       = shift_en ? shreg[1] : shreg[0];
  assign bit_done      = active && (baud_cnt == BAUD_LAST);
  assign last_data_bit = (bit_cnt == BIT_LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter control: frame sequencing, parity latch and the registered
// serial line / busy outputs.
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// START  | start bit (low) for one bit time
// DATA   | payload bits, LSB first
// PARITY | latched parity bit for one bit time
// STOP   | stop bit (high); may accept the next word on its last cycle
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  uart_state_e state, next_state;
  logic tx_next, busy_next;
  logic load, shift_en, active;
  logic ser_bit, bit_done, last_data_bit;
  logic par_en_q, par_bit_q, par_bit_in;

  assign active = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);
  assign par_bit_in = (PAR_TYP == PAR_EVEN) ? ^P_DATA : ~^P_DATA;

  uart_tx_serializer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .CLK          (CLK),
    .RST          (RST),
    .load         (load),
    .active       (active),
    .shift_en     (shift_en),
    .load_data    (P_DATA),
    .ser_bit      (ser_bit),
    .bit_done     (bit_done),
    .last_data_bit(last_data_bit)
  );

  always_comb begin
    next_state = state;
    tx_next    = 1'b1;
    busy_next  = 1'b1;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (DATA_VALID) begin
          load       = 1'b1;
          next_state = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_done) begin
          next_state = DATA;
          tx_next    = ser_bit;
        end
      end
      DATA: begin
        tx_next = ser_bit;
        if (bit_done) begin
          shift_en = 1'b1;
          tx_next  = ser_bit;
          if (last_data_bit) begin
            next_state = par_en_q ? PARITY : STOP;
            tx_next    = par_en_q ? par_bit_q : 1'b1;
          end
        end
      end
      PARITY: begin
        tx_next = par_bit_q;
        if (bit_done) begin
          next_state = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (DATA_VALID) begin
            load       = 1'b1;
            next_state = START;
            tx_next    = 1'b0;
          end else begin
            next_state = IDLE;
            busy_next  = 1'b0;
          end
        end
      end
      default: begin
        next_state = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state  <= next_state;
      TX_OUT <= tx_next;
      BUSY   <= busy_next;
      if (load) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= par_bit_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: frame shapes, parity, back-to-back,
// ignored requests and reset behaviour.
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       BUSY;

  int checks = 0;
  int failures = 0;

  logic cap_tx   [0:255];
  logic cap_busy [0:255];

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.DATA_WIDTH(8), .CLKS_PER_BIT(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a word at a falling edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input bit hold);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) DATA_VALID = 1'b0;
  endtask

  // Record TX_OUT/BUSY at the n falling edges following the accepting edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cap_tx[i]   = TX_OUT;
      cap_busy[i] = BUSY;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DATA_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_in: tx=%b busy=%b required tx=1 busy=0", TX_OUT, BUSY);
    end
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: tx=%b busy=%b required tx=1 busy=0", TX_OUT, BUSY);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0]  d  [4];
    logic        pe [4];
    logic        pt [4];
    logic [0:10] ex [4];
    int          nb [4];
    int          bcnt;
    d[0] = 8'hA5; pe[0] = 1; pt[0] = 0; ex[0] = 11'b01010010101; nb[0] = 11;
    d[1] = 8'h07; pe[1] = 1; pt[1] = 1; ex[1] = 11'b01110000001; nb[1] = 11;
    d[2] = 8'h03; pe[2] = 1; pt[2] = 1; ex[2] = 11'b01100000011; nb[2] = 11;
    d[3] = 8'h3C; pe[3] = 0; pt[3] = 0; ex[3] = 11'b00011110010; nb[3] = 10;
    for (int v = 0; v < 4; v++) begin
      send(d[v], pe[v], pt[v], 1'b0);
      P_DATA = ~d[v]; PAR_EN = ~pe[v]; PAR_TYP = ~pt[v];
      capture(96);
      for (int j = 0; j < nb[v]; j++)
        for (int c = 0; c < 8; c++) begin
          checks++;
          if (cap_tx[j*8+c] !== ex[v][j]) begin
            failures++;
            $display("FAIL frame_bit data=%h bit=%0d cyc=%0d: tx=%b required %b",
                     d[v], j, c, cap_tx[j*8+c], ex[v][j]);
          end
        end
      bcnt = 0;
      for (int i = 0; i < 96; i++) if (cap_busy[i] === 1'b1) bcnt++;
      checks++;
      if (bcnt !== nb[v]*8) begin
        failures++;
        $display("FAIL busy_len data=%h: %0d cycles required %0d", d[v], bcnt, nb[v]*8);
      end
      checks++;
      if (cap_busy[nb[v]*8] !== 1'b0 || cap_tx[nb[v]*8] !== 1'b1) begin
        failures++;
        $display("FAIL frame_end data=%h: tx=%b busy=%b required tx=1 busy=0",
                 d[v], cap_tx[nb[v]*8], cap_busy[nb[v]*8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:10] e1, e2;
    e1 = 11'b01010101001;
    e2 = 11'b00101010101;
    send(8'h55, 1'b1, 1'b0, 1'b1);
    fork
      capture(184);
      begin
        repeat (87) @(posedge CLK);
        #1 P_DATA = 8'hAA;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
      end
    join
    for (int j = 0; j < 11; j++) begin
      checks++;
      if (cap_tx[j*8+4] !== e1[j]) begin
        failures++;
        $display("FAIL b2b_first bit=%0d: tx=%b required %b", j, cap_tx[j*8+4], e1[j]);
      end
      checks++;
      if (cap_tx[88+j*8+4] !== e2[j]) begin
        failures++;
        $display("FAIL b2b_second bit=%0d: tx=%b required %b", j, cap_tx[88+j*8+4], e2[j]);
      end
    end
    checks++;
    if (cap_tx[87] !== 1'b1 || cap_tx[88] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_seam: tx87=%b tx88=%b required 1 then 0", cap_tx[87], cap_tx[88]);
    end
    for (int i = 0; i < 176; i++) begin
      checks++;
      if (cap_busy[i] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_busy cyc=%0d: busy=%b required 1", i, cap_busy[i]);
      end
    end
    checks++;
    if (cap_busy[176] !== 1'b0 || cap_tx[176] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: tx=%b busy=%b required tx=1 busy=0", cap_tx[176], cap_busy[176]);
    end
  endtask

  task automatic test_ignore_valid();
    int bcnt;
    send(8'h00, 1'b1, 1'b0, 1'b0);
    fork
      capture(100);
      begin
        repeat (35) @(posedge CLK);
        #1 P_DATA = 8'hFF; DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
      end
    join
    for (int i = 0; i < 80; i++) begin
      checks++;
      if (cap_tx[i] !== 1'b0) begin
        failures++;
        $display("FAIL ignore_data cyc=%0d: tx=%b required 0", i, cap_tx[i]);
      end
    end
    bcnt = 0;
    for (int i = 0; i < 100; i++) if (cap_busy[i] === 1'b1) bcnt++;
    checks++;
    if (bcnt !== 88) begin
      failures++;
      $display("FAIL ignore_busy_len: %0d cycles required 88", bcnt);
    end
    for (int i = 80; i < 100; i++) begin
      checks++;
      if (cap_tx[i] !== 1'b1) begin
        failures++;
        $display("FAIL ignore_tail cyc=%0d: tx=%b required 1", i, cap_tx[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [0:10] ex;
    int bcnt;
    ex = 11'b01111000011;
    send(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (43) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: tx=%b busy=%b required tx=0 busy=1", TX_OUT, BUSY);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL mid_abort: tx=%b busy=%b required tx=1 busy=0", TX_OUT, BUSY);
    end
    @(posedge CLK);
    send(8'h0F, 1'b1, 1'b1, 1'b0);
    capture(96);
    for (int j = 0; j < 11; j++) begin
      checks++;
      if (cap_tx[j*8+4] !== ex[j]) begin
        failures++;
        $display("FAIL mid_restart bit=%0d: tx=%b required %b", j, cap_tx[j*8+4], ex[j]);
      end
    end
    bcnt = 0;
    for (int i = 0; i < 96; i++) if (cap_busy[i] === 1'b1) bcnt++;
    checks++;
    if (bcnt !== 88) begin
      failures++;
      $display("FAIL mid_restart_busy: %0d cycles required 88", bcnt);
    end
  endtask

  task automatic test_reset_with_valid();
    @(negedge CLK);
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0; DATA_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL rst_valid cyc=%0d: tx=%b busy=%b required tx=1 busy=0", i, TX_OUT, BUSY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_back_to_back();
    test_ignore_valid();
    test_mid_reset();
    test_reset_with_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
